// File: rtl/float_to_int.sv
// float_to_int: IEEE-754 single to signed 32-bit integer, RNE, saturating, with fcvt.w.s nv/nx flags.
module float_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_nv,
  output logic        output_z_nx,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  typedef enum logic [2:0] {get_a, unpack, special_cases, align, round, pack, put_z} state_t;
  state_t state, state_nxt;
  logic [31:0] a, mag, z;
  logic [23:0] m;
  logic signed [9:0] e;
  logic s, guard, sticky, nv, nx;
  logic nan, inf, zero, big, tiny, special;
  logic [5:0] sh;
  logic [63:0] fx;
  always_comb begin
    nan = (&a[30:23]) && (|a[22:0]);
    inf = (&a[30:23]) && !(|a[22:0]);
    zero = ~|a[30:0];
    big = e >= 10'sd31;
    tiny = e <= -10'sd2;
    special = nan | inf | big | zero | tiny;
    // 32 fractional bits below the integer part; e is in [-1,30] here so the shift fits 6 bits
    sh = e[5:0] + 6'd9;
    fx = {40'd0, m} << sh;
    state_nxt = state;
    case (state)
      get_a:         state_nxt = (input_a_ack && input_a_stb) ? unpack : get_a;
      unpack:        state_nxt = special_cases;
      special_cases: state_nxt = special ? put_z : align;
      align:         state_nxt = round;
      round:         state_nxt = pack;
      pack:          state_nxt = put_z;
      put_z:         state_nxt = (output_z_stb && output_z_ack) ? get_a : put_z;
      default:       state_nxt = get_a;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= get_a;
      input_a_ack <= 1'b0;
      output_z_stb <= 1'b0;
      output_z <= 32'd0;
      output_z_nv <= 1'b0;
      output_z_nx <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        get_a: begin
          if (input_a_ack && input_a_stb) begin
            a <= input_a;
            input_a_ack <= 1'b0;
          end else input_a_ack <= 1'b1;
        end
        unpack: begin
          s <= a[31];
          e <= $signed({2'b00, a[30:23]}) - 10'sd127;
          m <= {|a[30:23], a[22:0]};
        end
        special_cases: begin
          nv <= nan | inf | (big && a != 32'hCF000000);
          nx <= !(nan | inf | big | zero) && tiny;
          z <= nan ? 32'h7FFFFFFF : (inf | big) ? (s ? 32'h80000000 : 32'h7FFFFFFF) : 32'd0;
        end
        align: begin
          mag <= fx[63:32];
          guard <= fx[31];
          sticky <= |fx[30:0];
        end
        round: begin
          mag <= mag + {31'd0, guard && (sticky || mag[0])};
          nx <= guard | sticky;
          nv <= 1'b0;
        end
        pack: begin
          if (mag[31]) begin
            z <= s ? 32'h80000000 : 32'h7FFFFFFF;
            nv <= 1'b1;
            nx <= 1'b0;
          end else z <= s ? -mag : mag;
        end
        put_z: begin
          if (!output_z_stb) begin
            output_z_stb <= 1'b1;
            output_z <= z;
            output_z_nv <= nv;
            output_z_nx <= nx;
          end else if (output_z_ack) output_z_stb <= 1'b0;
        end
        default: input_a_ack <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int: directed vector table plus latency, backpressure and reset sequences.
module tb_float_to_int;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] input_a = 32'd0, output_z;
  logic input_a_stb = 1'b0, input_a_ack, output_z_nv, output_z_nx, output_z_stb, output_z_ack = 1'b0;
  int checks = 0, failures = 0;

  float_to_int dut (
    .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .output_z(output_z), .output_z_nv(output_z_nv), .output_z_nx(output_z_nx),
    .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    logic nv;
    logic nx;
    int lat;
  } vec_t;
  vec_t v[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // called at a negedge; returns with the result visible at a negedge
  task automatic do_op(input logic [31:0] a, output int lat);
    int w = 0;
    while (!input_a_ack && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ack_ready", {31'd0, input_a_ack}, 32'd1);
    input_a = a;
    input_a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    input_a = 32'hDEADBEEF;
    lat = 0;
    while (!output_z_stb && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("stb_fall", {31'd0, output_z_stb}, 32'd0);
    output_z_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bit saw;
    v[0]  = '{32'h40490FDB, 32'd3,         1'b0, 1'b1, 6};
    v[1]  = '{32'h3FC00000, 32'd2,         1'b0, 1'b1, 6};
    v[2]  = '{32'h40200000, 32'd2,         1'b0, 1'b1, 6};
    v[3]  = '{32'h41200000, 32'd10,        1'b0, 1'b0, 6};
    v[4]  = '{32'hC0200000, 32'hFFFFFFFE,  1'b0, 1'b1, 6};
    v[5]  = '{32'hBF400000, 32'hFFFFFFFF,  1'b0, 1'b1, 6};
    v[6]  = '{32'hBE800000, 32'd0,         1'b0, 1'b1, 3};
    v[7]  = '{32'h4F000000, 32'h7FFFFFFF,  1'b1, 1'b0, 3};
    v[8]  = '{32'hCF000000, 32'h80000000,  1'b0, 1'b0, 3};
    v[9]  = '{32'h7FC00000, 32'h7FFFFFFF,  1'b1, 1'b0, 3};
    v[10] = '{32'hFF800000, 32'h80000000,  1'b1, 1'b0, 3};
    v[11] = '{32'h4EFFFFFF, 32'h7FFFFF80,  1'b0, 1'b0, 6};
    v[12] = '{32'h80000000, 32'd0,         1'b0, 1'b0, 3};
    v[13] = '{32'h00000001, 32'd0,         1'b0, 1'b1, 3};
    v[14] = '{32'h3F000000, 32'd0,         1'b0, 1'b1, 6};
    v[15] = '{32'h3F000001, 32'd1,         1'b0, 1'b1, 6};
    v[16] = '{32'h7F800000, 32'h7FFFFFFF,  1'b1, 1'b0, 3};
    v[17] = '{32'hBF800000, 32'hFFFFFFFF,  1'b0, 1'b0, 6};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'd0, input_a_ack}, 32'd0);
    chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
    chk("rst_z", output_z, 32'd0);
    chk("rst_nv", {31'd0, output_z_nv}, 32'd0);
    chk("rst_nx", {31'd0, output_z_nx}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_after_rst", {31'd0, input_a_ack}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      do_op(v[i].a, lat);
      chk($sformatf("lat[%0d]", i), lat, v[i].lat);
      chk($sformatf("z[%0d]", i), output_z, v[i].z);
      chk($sformatf("nv[%0d]", i), {31'd0, output_z_nv}, {31'd0, v[i].nv});
      chk($sformatf("nx[%0d]", i), {31'd0, output_z_nx}, {31'd0, v[i].nx});
      consume();
    end

    // backpressure: result must hold while ack stays low
    do_op(32'h40490FDB, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_stb", {31'd0, output_z_stb}, 32'd1);
      chk("hold_z", output_z, 32'd3);
      chk("hold_flags", {30'd0, output_z_nv, output_z_nx}, 32'd1);
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_stb_fall", {31'd0, output_z_stb}, 32'd0);
    chk("bp_ack_low", {31'd0, input_a_ack}, 32'd0);
    output_z_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_ack_rise", {31'd0, input_a_ack}, 32'd1);
    @(negedge clk);

    // reset while in align aborts the conversion
    input_a = 32'h41200000;
    input_a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ack", {31'd0, input_a_ack}, 32'd0);
    chk("mid_rst_z", output_z, 32'd0);
    chk("mid_rst_flags", {30'd0, output_z_nv, output_z_nx}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_ack_rise", {31'd0, input_a_ack}, 32'd1);
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      saw |= output_z_stb;
    end
    chk("mid_rst_no_stb", {31'd0, saw}, 32'd0);
    @(negedge clk);
    do_op(32'h40400000, lat);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_z", output_z, 32'd3);
    chk("post_rst_flags", {30'd0, output_z_nv, output_z_nx}, 32'd0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
